// File: rtl/alu_uart_frontend.sv
// ============================================================================
// Module   : alu_uart_frontend
// Brief    : UART byte-stream command front end for the EX-stage ALU.
//            Optional RX inter-byte timeout: ALU_UART_FRONTEND_RX_TIMEOUT_EN
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef DEFAULT_ALU_IO_BUS_WIDTH
`define DEFAULT_ALU_IO_BUS_WIDTH 32
`endif
`ifndef DEFAULT_ALU_CTR_BUS_WIDTH
`define DEFAULT_ALU_CTR_BUS_WIDTH 6
`endif

module alu_uart_frontend #(
    parameter int IO_BUS_WIDTH   = `DEFAULT_ALU_IO_BUS_WIDTH,
    parameter int CTR_BUS_WIDTH  = `DEFAULT_ALU_CTR_BUS_WIDTH,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_done,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_done,
    output logic [CTR_BUS_WIDTH-1:0] o_alu_ctr_code,
    output logic [IO_BUS_WIDTH-1:0]  o_alu_data_a,
    output logic [IO_BUS_WIDTH-1:0]  o_alu_data_b,
    input  logic [IO_BUS_WIDTH-1:0]  i_alu_result,
    output logic                     o_busy,
    output logic                     o_frame_err
);

    localparam int c_NB = IO_BUS_WIDTH / 8;
    localparam int c_CW = $clog2(c_NB) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_A    = 3'd1,
        S_RX_B    = 3'd2,
        S_EXEC    = 3'd3,
        S_TX_LOAD = 3'd4,
        S_TX_WAIT = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [c_CW-1:0]          r_cnt;
    logic [CTR_BUS_WIDTH-1:0] r_ctr_code;
    logic [IO_BUS_WIDTH-1:0]  r_data_a;
    logic [IO_BUS_WIDTH-1:0]  r_data_b;
    logic [IO_BUS_WIDTH-1:0]  r_result;
    logic [7:0]               r_tx_data;
    logic                     r_tx_start;
    logic                     w_last;
    logic                     w_timeout;

    assign w_last = (r_cnt == c_CW'(c_NB - 1));

`ifdef ALU_UART_FRONTEND_RX_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TW-1:0] r_idle_cnt;
    logic            r_frame_err;
    logic            w_in_rx;

    assign w_in_rx   = (r_state == S_RX_A) || (r_state == S_RX_B);
    assign w_timeout = w_in_rx && !i_rx_done && (r_idle_cnt == c_TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_idle_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_in_rx && !i_rx_done && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
            if (w_timeout) begin
                r_frame_err <= 1'b1;
            end else if ((r_state == S_IDLE) && i_rx_done) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_frame_err = r_frame_err;
`else
    assign w_timeout   = 1'b0;
    assign o_frame_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_done) w_next = S_RX_A;
            end
            S_RX_A: begin
                if (w_timeout)                w_next = S_IDLE;
                else if (i_rx_done && w_last) w_next = S_RX_B;
            end
            S_RX_B: begin
                if (w_timeout)                w_next = S_IDLE;
                else if (i_rx_done && w_last) w_next = S_EXEC;
            end
            S_EXEC:    w_next = S_TX_LOAD;
            S_TX_LOAD: w_next = S_TX_WAIT;
            S_TX_WAIT: begin
                if (i_tx_done) w_next = w_last ? S_IDLE : S_TX_LOAD;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Stray i_rx_done / i_tx_done in the wrong state fall through untouched.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt      <= '0;
            r_ctr_code <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_result   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_rx_done) begin
                        r_ctr_code <= i_rx_data[CTR_BUS_WIDTH-1:0];
                        r_cnt      <= '0;
                    end
                end
                S_RX_A: begin
                    if (w_timeout) begin
                        r_cnt <= '0;
                    end else if (i_rx_done) begin
                        r_data_a[8*r_cnt +: 8] <= i_rx_data;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_RX_B: begin
                    if (w_timeout) begin
                        r_cnt <= '0;
                    end else if (i_rx_done) begin
                        r_data_b[8*r_cnt +: 8] <= i_rx_data;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_result <= i_alu_result;
                    r_cnt    <= '0;
                end
                S_TX_LOAD: begin
                    r_tx_data  <= r_result[8*r_cnt +: 8];
                    r_tx_start <= 1'b1;
                end
                S_TX_WAIT: begin
                    if (i_tx_done) r_cnt <= r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_tx_data      = r_tx_data;
    assign o_tx_start     = r_tx_start;
    assign o_alu_ctr_code = r_ctr_code;
    assign o_alu_data_a   = r_data_a;
    assign o_alu_data_b   = r_data_b;
    assign o_busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire
